// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryptor, one round per clock.
//   A load pulse captures the key and expands rk1..rk10 into a round-key store,
//   one key per cycle. A start pulse captures a ciphertext block and runs the
//   inverse cipher, one round per cycle. The result appears on oBlock 10 edges
//   after the accepted start.
// Optional feature: define AES_INV_CBC_CHAIN_EN for CBC chaining. This adds the
//   iv port and a chain register. Without it the block runs in ECB mode.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-low reset
//   load    capture key (and iv) and start key expansion
//   start   capture iBlock and start decryption
//   key     128-bit cipher key
//   iv      128-bit initial chain value (AES_INV_CBC_CHAIN_EN only)
//   iBlock  128-bit ciphertext block
//   oBlock  registered 128-bit plaintext block
//   idle    registered ready indication
module aes_inv_cipher #(
  parameter int unsigned NUM_ROUNDS = 10  // AES-128 only
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         start,
  input  logic [127:0] key,
`ifdef AES_INV_CBC_CHAIN_EN
  input  logic [127:0] iv,
`endif
  input  logic [127:0] iBlock,
  output logic [127:0] oBlock,
  output logic         idle
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} state_t;

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x09, 0x0b, 0x0d, 0x0e) in GF(2^8).
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = b;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  // Round constant for expansion step r (1..10).
  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Derive the next round key from the previous one.
  function automatic logic [127:0] next_round_key(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {SBOX[prev[23:16]], SBOX[prev[15:8]], SBOX[prev[7:0]], SBOX[prev[31:24]]} ^ {rc, 24'h0};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
  // Byte i of the block is state row i%4, column i/4.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        t[w+4*c] = INV_SBOX[b[w+4*((c-w+4)%4)]] ^ rk[127-8*(w+4*c) -: 8];
    for (int c = 0; c < 4; c++) begin
      if (mix) begin
        r[127-32*c -: 8] = gmul(t[4*c], 4'he) ^ gmul(t[4*c+1], 4'hb) ^
                           gmul(t[4*c+2], 4'hd) ^ gmul(t[4*c+3], 4'h9);
        r[119-32*c -: 8] = gmul(t[4*c], 4'h9) ^ gmul(t[4*c+1], 4'he) ^
                           gmul(t[4*c+2], 4'hb) ^ gmul(t[4*c+3], 4'hd);
        r[111-32*c -: 8] = gmul(t[4*c], 4'hd) ^ gmul(t[4*c+1], 4'h9) ^
                           gmul(t[4*c+2], 4'he) ^ gmul(t[4*c+3], 4'hb);
        r[103-32*c -: 8] = gmul(t[4*c], 4'hb) ^ gmul(t[4*c+1], 4'hd) ^
                           gmul(t[4*c+2], 4'h9) ^ gmul(t[4*c+3], 4'he);
      end else begin
        r[127-32*c -: 32] = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
      end
    end
    return r;
  endfunction

  state_t           state, state_nx;
  logic [CNT_W-1:0] rnd_cnt;
  logic             key_valid;
  logic [BLK_W-1:0] st;
  logic [BLK_W-1:0] rk_store [0:NUM_ROUNDS];
  logic [BLK_W-1:0] rk_next;
  logic [BLK_W-1:0] rnd_out;
  logic             cap_key, cap_blk, kexp_step, rnd_step, rnd_last;
`ifdef AES_INV_CBC_CHAIN_EN
  logic [BLK_W-1:0] chain;
  logic [BLK_W-1:0] blk_cap;
`endif

  // One shared key-expansion step and one shared round datapath.
  assign rk_next = next_round_key(rk_store[CNT_W'(rnd_cnt - 1'b1)], rcon(rnd_cnt));
  assign rnd_out = inv_round(st, rk_store[CNT_W'(LAST_RND - rnd_cnt)], !rnd_last);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic. Load has priority over start in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (load)                   state_nx = KEYEXP;
        else if (start && key_valid) state_nx = ROUND;
      end
      KEYEXP:  if (rnd_cnt == LAST_RND) state_nx = IDLE;
      ROUND:   if (rnd_cnt == LAST_RND) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath control strobes.
  always_comb begin
    cap_key   = 1'b0;
    cap_blk   = 1'b0;
    kexp_step = 1'b0;
    rnd_step  = 1'b0;
    rnd_last  = 1'b0;
    case (state)
      IDLE: begin
        cap_key = load;
        cap_blk = !load && start && key_valid;
      end
      KEYEXP:  kexp_step = 1'b1;
      ROUND: begin
        rnd_step = (rnd_cnt != LAST_RND);
        rnd_last = (rnd_cnt == LAST_RND);
      end
      default: ;
    endcase
  end

  // Round-key store; contents are meaningless until key_valid.
  always_ff @(posedge clk) begin
    if (cap_key)        rk_store[0]       <= key;
    else if (kexp_step) rk_store[rnd_cnt] <= rk_next;
  end

  // Counter, state block, result and ready flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rnd_cnt   <= '0;
      key_valid <= 1'b0;
      st        <= '0;
      oBlock    <= '0;
      idle      <= 1'b1;
`ifdef AES_INV_CBC_CHAIN_EN
      chain     <= '0;
      blk_cap   <= '0;
`endif
    end else begin
      // idle lags the accept edge by one cycle and rises with the result
      idle <= (state == IDLE) || (state_nx == IDLE);
      if (cap_key || cap_blk)          rnd_cnt <= CNT_W'(1);
      else if (state != IDLE)          rnd_cnt <= (rnd_cnt == LAST_RND) ? '0 : CNT_W'(rnd_cnt + 1'b1);
      if (kexp_step && rnd_cnt == LAST_RND) key_valid <= 1'b1;
      if (cap_blk)       st <= iBlock ^ rk_store[LAST_RND];
      else if (rnd_step) st <= rnd_out;
`ifdef AES_INV_CBC_CHAIN_EN
      if (cap_key) chain   <= iv;
      if (cap_blk) blk_cap <= iBlock;
      if (rnd_last) begin
        oBlock <= rnd_out ^ chain;
        chain  <= blk_cap;
      end
`else
      if (rnd_last) oBlock <= rnd_out;
`endif
    end
  end

endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning AES-128 round count; only 10 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port load  input  1  pulse that captures key (and iv when chaining is enabled) and starts key expansion.
REQ-005 SHALL have port start  input  1  pulse that captures iBlock and starts decryption.
REQ-006 SHALL have port key  input  128  cipher key, sampled only on an accepted load.
REQ-007 SHALL have port iBlock  input  128  ciphertext block, sampled only on an accepted start.
REQ-008 SHALL have port oBlock  output  128  registered plaintext block.
REQ-009 SHALL have port idle  output  1  high when the block is ready to accept load or start.

Function
REQ-010 SHALL implement an FSM with states IDLE, KEYEXP and ROUND.
REQ-011 SHALL accept load only in IDLE; if load and start are both high in the same cycle, load SHALL win and start SHALL be dropped.
REQ-012 SHALL, on load accepted at edge N, compute one round key per cycle (rk1..rk10) into an 11-entry store; idle SHALL be low from N+1 and high at N+10.
REQ-013 SHALL accept start only in IDLE with key_valid set; a start outside these conditions SHALL be ignored, with no state change and oBlock held.
REQ-014 SHALL, on start accepted at edge N, apply AddRoundKey(rk10) at capture, then run 9 cycles of InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns, then one final round without InvMixColumns.
REQ-015 SHALL, for start accepted at edge N, update oBlock and raise idle at edge N+10, holding idle low from N+1 to N+9.
REQ-016 SHALL hold oBlock stable between completions, including during a subsequent key expansion.
REQ-017 SHALL ignore load and start asserted while busy; they are not queued.
REQ-018 SHALL set key_valid at the end of the first key expansion; key_valid SHALL stay set across later loads.
REQ-019 SHALL use a 4-bit round counter that counts 1..10 and clears on return to IDLE.

Reset
REQ-020 SHALL, while rst is low at a clock edge, force the FSM to IDLE, idle to 1, oBlock to 0, key_valid to 0, the round counter to 0 and the chain register to 0.
REQ-021 SHALL, on reset asserted mid-KEYEXP or mid-ROUND, abort the operation with no partial oBlock update; a new load SHALL be required before start is accepted.

Configuration
REQ-022 SHALL, when macro AES_INV_CBC_CHAIN_EN is defined, add port iv (input, 128 bits, captured on load) and a 128-bit chain register, and otherwise behave per REQ-023 to REQ-025 below.
REQ-023 SHALL, with AES_INV_CBC_CHAIN_EN defined, load the chain register from iv on an accepted load.
REQ-024 SHALL, with AES_INV_CBC_CHAIN_EN defined, produce oBlock = InvCipher(iBlock) XOR chain at each completion and, in the same edge, load chain from the iBlock captured at start.
REQ-025 SHALL, without AES_INV_CBC_CHAIN_EN, have no iv port and no chain register, and produce oBlock = InvCipher(iBlock) (ECB); timing SHALL be identical in both builds.

Verification
REQ-026 SHALL cover: load key 000102030405060708090a0b0c0d0e0f, then start iBlock 69c4e0d86a7b0430d8cdb78070b4c55a -> oBlock 00112233445566778899aabbccddeeff at start+10 (ECB build).
REQ-027 SHALL cover: load key 2b7e151628aed2a6abf7158809cf4f3c, then start 3ad77bb40d7a3660a89ecaf32466ef97 -> oBlock 6bc1bee22e409f96e93d7e117393172a (ECB build); idle SHALL be low for exactly 9 cycles.
REQ-028 SHALL cover: CBC build, same key, iv 000102030405060708090a0b0c0d0e0f, start 7649abac8119b246cee98e9b12e9197d -> 6bc1bee22e409f96e93d7e117393172a, then start 5086cb9b507219ee95db113a917678b2 -> ae2d8a571e03ac9c9eb76fac45af8e51.
REQ-029 SHALL cover: start after reset with no load -> ignored, idle stays 1 and oBlock stays 0; start asserted at round 5 -> ignored and the result is unchanged.
REQ-030 SHALL cover: reset asserted at round 4 -> next cycle shows idle 1 and oBlock 0; start without a reload is ignored; reload plus REQ-026 stimulus passes.
REQ-031 SHALL cover: load and start high in the same IDLE cycle -> key expansion only, and oBlock holds its prior value.
